// File: rtl/uart_rx_ctrl.sv
// UART receiver: 3-sample majority vote per bit, optional parity, 1/2 stop bits.
// Frame settings are captured at the start of each frame and held until DONE.
module uart_rx_ctrl #(
  parameter int DATA_W    = 8,
  parameter int PRESC_W   = 6,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX_IN,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic [PRESC_W-1:0] pre_scale,
  output logic [DATA_W-1:0]  p_data,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               strt_glitch,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t              state;
  logic [PRESC_W-1:0]  edge_cnt;
  logic [3:0]          bit_cnt;
  logic [PRESC_W-1:0]  presc;
  logic                par_en_q;
  logic                par_typ_q;
  logic [2:0]          smp;
  logic [DATA_W-1:0]   shreg;
  logic                par_flag;
  logic                stp_flag;

  logic [PRESC_W-1:0]  presc_in;
  logic [PRESC_W-1:0]  half;
  logic [PRESC_W-1:0]  nxt_edge;
  logic                last_edge;
  logic                stop_edge;
  logic                last_stop;
  logic                vote;
  logic                stop_bad;
  logic                par_exp;
  logic                enter_start;

  // Odd or too-small prescales would put the vote window off-centre
  assign presc_in = (pre_scale < PRESC_W'(8)) ? PRESC_W'(8)
                  : {pre_scale[PRESC_W-1:1], 1'b0};

  assign half      = presc >> 1;
  assign last_edge = edge_cnt == presc - PRESC_W'(1);
  assign stop_edge = edge_cnt == presc - PRESC_W'(2);
  assign nxt_edge  = last_edge ? '0 : edge_cnt + PRESC_W'(1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2])
                   | (smp[1] & smp[2]);
  assign stop_bad  = stp_flag | ~vote;
  assign par_exp   = (^shreg) ^ par_typ_q;
  assign busy      = state != IDLE;

  assign enter_start = ((state == IDLE) || (state == DONE)) && !RX_IN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      presc       <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      smp         <= '0;
      shreg       <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      p_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;

      if (edge_cnt == half - PRESC_W'(1)) smp[0] <= RX_IN;
      if (edge_cnt == half)               smp[1] <= RX_IN;
      if (edge_cnt == half + PRESC_W'(1)) smp[2] <= RX_IN;

      unique case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (!RX_IN) state <= START;
        end
        START: begin
          edge_cnt <= nxt_edge;
          if (last_edge) begin
            if (vote) begin
              strt_glitch <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          edge_cnt <= nxt_edge;
          if (last_edge) begin
            shreg <= {vote, shreg[DATA_W-1:1]};
            if (bit_cnt == 4'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          edge_cnt <= nxt_edge;
          if (last_edge) begin
            if (vote != par_exp) par_flag <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          // Final stop bit ends one edge early so DONE fits in the frame
          if (last_stop && stop_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            stp_flag <= stop_bad;
            state    <= DONE;
            if (!stop_bad && !par_flag) begin
              data_valid <= 1'b1;
              p_data     <= shreg;
            end else begin
              par_err <= par_flag;
              stp_err <= stop_bad;
            end
          end else begin
            edge_cnt <= nxt_edge;
            if (last_edge) begin
              if (!vote) stp_flag <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        DONE: begin
          state <= RX_IN ? IDLE : START;
        end
        default: state <= IDLE;
      endcase

      if (enter_start) begin
        edge_cnt  <= '0;
        bit_cnt   <= '0;
        presc     <= presc_in;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        par_flag  <= 1'b0;
        stp_flag  <= 1'b0;
        shreg     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus random frames against
// a frame-level model (bit list, parity/stop rules, N*P latency).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] pre_scale = 6'd8;

  logic [7:0] pd0, pd1;
  logic dv0, pe0, se0, sg0, bz0;
  logic dv1, pe1, se1, sg1, bz1;

  uart_rx_ctrl #(.DATA_W(8), .PRESC_W(6), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx0),
    .par_en(par_en), .par_typ(par_typ), .pre_scale(pre_scale),
    .p_data(pd0), .data_valid(dv0), .par_err(pe0),
    .stp_err(se0), .strt_glitch(sg0), .busy(bz0)
  );

  uart_rx_ctrl #(.DATA_W(8), .PRESC_W(6), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx1),
    .par_en(par_en), .par_typ(par_typ), .pre_scale(pre_scale),
    .p_data(pd1), .data_valid(dv1), .par_err(pe1),
    .stp_err(se1), .strt_glitch(sg1), .busy(bz1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] k;
    logic [7:0] d;
  } ev_t;

  ev_t ev0[$];
  ev_t ev1[$];

  // kind = {data_valid, par_err, stp_err, strt_glitch}
  always @(negedge clk) begin
    if ({dv0, pe0, se0, sg0} != 4'b0)
      ev0.push_back(ev_t'{cyc, {dv0, pe0, se0, sg0}, pd0});
    if ({dv1, pe1, se1, sg1} != 4'b0)
      ev1.push_back(ev_t'{cyc, {dv1, pe1, se1, sg1}, pd1});
  end

  int checks = 0;
  int failures = 0;
  bit fr[$];
  logic [7:0] exp_pd0 = 8'h00;

  function automatic int eff_p(input logic [5:0] ps);
    return (ps < 6'd8) ? 8 : int'(ps) / 2 * 2;
  endfunction

  task automatic append_frame(input logic [7:0] d, input bit pe,
                              input bit pt, input bit bad_par,
                              input int nstop, input int bad_stop);
    fr.push_back(1'b0);
    for (int i = 0; i < 8; i++) fr.push_back(d[i]);
    if (pe) fr.push_back((^d) ^ pt ^ bad_par);
    for (int s = 0; s < nstop; s++) fr.push_back(s != bad_stop);
  endtask

  task automatic send(input int sel, input int p, output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    foreach (fr[i]) begin
      if (sel == 0) rx0 = fr[i];
      else          rx1 = fr[i];
      repeat (p) @(posedge clk);
      #1;
    end
    rx0 = 1'b1;
    rx1 = 1'b1;
    fr.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pd0, dv0, pe0, se0, sg0, bz0} !== 13'b0) begin
      failures++;
      $display("FAIL reset_u0 got=%h want=0",
               {pd0, dv0, pe0, se0, sg0, bz0});
    end
    checks++;
    if ({pd1, dv1, pe1, se1, sg1, bz1} !== 13'b0) begin
      failures++;
      $display("FAIL reset_u1 got=%h want=0",
               {pd1, dv1, pe1, se1, sg1, bz1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    checks++;
    if (bz0 !== 1'b0 || ev0.size() != 0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b ev=%0d want 0/0",
               bz0, ev0.size());
    end
  endtask

  task automatic test_basic();
    int c0;
    ev0.delete();
    par_en = 1'b1; par_typ = 1'b0; pre_scale = 6'd8;
    append_frame(8'hA5, 1, 0, 0, 1, -1);
    send(0, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev0.size() != 1) begin
      failures++;
      $display("FAIL basic_events got=%0d want=1", ev0.size());
    end else begin
      checks++;
      if (ev0[0].cyc !== c0 + 88 || ev0[0].k !== 4'b1000 ||
          ev0[0].d !== 8'hA5) begin
        failures++;
        $display("FAIL basic_frame got cyc=%0d k=%b d=%h want %0d 1000 a5",
                 ev0[0].cyc - c0, ev0[0].k, ev0[0].d, 88);
      end
    end
    exp_pd0 = 8'hA5;
  endtask

  task automatic test_parity_err();
    int c0;
    ev0.delete();
    append_frame(8'hA5, 1, 0, 1, 1, -1);
    send(0, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev0.size() != 1) begin
      failures++;
      $display("FAIL parity_events got=%0d want=1", ev0.size());
    end else begin
      checks++;
      if (ev0[0].cyc !== c0 + 88 || ev0[0].k !== 4'b0100) begin
        failures++;
        $display("FAIL parity_pulse got cyc=%0d k=%b want 88 0100",
                 ev0[0].cyc - c0, ev0[0].k);
      end
    end
    checks++;
    if (pd0 !== exp_pd0) begin
      failures++;
      $display("FAIL parity_hold got=%h want=%h", pd0, exp_pd0);
    end
  endtask

  task automatic test_glitch();
    int c0;
    ev0.delete();
    pre_scale = 6'd16;
    @(posedge clk);
    #1;
    c0 = cyc;
    rx0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx0 = 1'b1;
    checks++;
    if (bz0 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_start got=%b want=1", bz0);
    end
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (ev0.size() != 1) begin
      failures++;
      $display("FAIL glitch_events got=%0d want=1", ev0.size());
    end else begin
      checks++;
      if (ev0[0].cyc !== c0 + 17 || ev0[0].k !== 4'b0001) begin
        failures++;
        $display("FAIL glitch_pulse got cyc=%0d k=%b want 17 0001",
                 ev0[0].cyc - c0, ev0[0].k);
      end
    end
    checks++;
    if (bz0 !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy_end got=%b want=0", bz0);
    end
  endtask

  task automatic test_stop2();
    int c0;
    ev1.delete();
    par_en = 1'b0; pre_scale = 6'd8;
    append_frame(8'h3C, 0, 0, 0, 2, -1);
    send(1, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev1.size() != 1 || ev1[0].cyc !== c0 + 88 ||
        ev1[0].k !== 4'b1000 || ev1[0].d !== 8'h3C) begin
      failures++;
      $display("FAIL stop2_good events=%0d want one dv 3c at 88",
               ev1.size());
    end
    ev1.delete();
    append_frame(8'h3C, 0, 0, 0, 2, 1);
    send(1, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev1.size() != 1) begin
      failures++;
      $display("FAIL stop2_events got=%0d want=1", ev1.size());
    end else begin
      checks++;
      if (ev1[0].cyc !== c0 + 88 || ev1[0].k !== 4'b0010) begin
        failures++;
        $display("FAIL stop2_pulse got cyc=%0d k=%b want 88 0010",
                 ev1[0].cyc - c0, ev1[0].k);
      end
    end
    checks++;
    if (pd1 !== 8'h3C) begin
      failures++;
      $display("FAIL stop2_hold got=%h want=3c", pd1);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    ev0.delete();
    par_en = 1'b1; par_typ = 1'b1; pre_scale = 6'd10;
    append_frame(8'h01, 1, 1, 0, 1, -1);
    append_frame(8'hFE, 1, 1, 0, 1, -1);
    send(0, 10, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev0.size() != 2) begin
      failures++;
      $display("FAIL b2b_events got=%0d want=2", ev0.size());
    end else begin
      checks++;
      if (ev0[0].cyc !== c0 + 110 || ev0[0].k !== 4'b1000 ||
          ev0[0].d !== 8'h01) begin
        failures++;
        $display("FAIL b2b_first got cyc=%0d k=%b d=%h want 110 1000 01",
                 ev0[0].cyc - c0, ev0[0].k, ev0[0].d);
      end
      checks++;
      if (ev0[1].cyc - ev0[0].cyc !== 110 || ev0[1].k !== 4'b1000 ||
          ev0[1].d !== 8'hFE) begin
        failures++;
        $display("FAIL b2b_second got gap=%0d k=%b d=%h want 110 1000 fe",
                 ev0[1].cyc - ev0[0].cyc, ev0[1].k, ev0[1].d);
      end
    end
    exp_pd0 = 8'hFE;
  endtask

  task automatic test_reset_mid();
    int c0;
    ev0.delete();
    par_en = 1'b0; pre_scale = 6'd8;
    append_frame(8'hAA, 0, 0, 0, 1, -1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      rx0 = fr[i];
      repeat (8) @(posedge clk);
      #1;
    end
    rx0 = fr[5];
    repeat (3) @(posedge clk);
    #2;
    fr.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pd0, dv0, pe0, se0, sg0, bz0} !== 13'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=0",
               {pd0, dv0, pe0, se0, sg0, bz0});
    end
    rx0 = 1'b1;
    exp_pd0 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bz0 !== 1'b0 || ev0.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_idle busy=%b ev=%0d want 0/0",
               bz0, ev0.size());
    end
    append_frame(8'h55, 0, 0, 0, 1, -1);
    send(0, 8, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ev0.size() != 1 || ev0[0].cyc !== c0 + 80 ||
        ev0[0].k !== 4'b1000 || ev0[0].d !== 8'h55) begin
      failures++;
      $display("FAIL reset_mid_frame events=%0d want one dv 55 at 80",
               ev0.size());
    end
    exp_pd0 = 8'h55;
  endtask

  task automatic test_random();
    int c0, p, n, mode;
    logic [7:0] d;
    bit pe, pt, want_pe, want_se;
    logic [3:0] kind;
    for (int t = 0; t < 16; t++) begin
      ev0.delete();
      d = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      mode = $urandom_range(0, 3);
      pre_scale = 6'($urandom_range(0, 63));
      par_en = pe;
      par_typ = pt;
      p = eff_p(pre_scale);
      n = 1 + 8 + (pe ? 1 : 0) + 1;
      want_pe = pe && mode == 1;
      want_se = mode == 2;
      append_frame(d, pe, pt, mode == 1, 1, mode == 2 ? 0 : -1);
      send(0, p, c0);
      kind = {!want_pe && !want_se, want_pe, want_se, 1'b0};
      if (kind[3]) exp_pd0 = d;
      repeat ($urandom_range(3, 12)) @(posedge clk);
      #1;
      checks++;
      if (ev0.size() != 1) begin
        failures++;
        $display("FAIL rand%0d_events got=%0d want=1", t, ev0.size());
      end else begin
        checks++;
        if (ev0[0].cyc !== c0 + n * p || ev0[0].k !== kind) begin
          failures++;
          $display("FAIL rand%0d_pulse got cyc=%0d k=%b want %0d %b",
                   t, ev0[0].cyc - c0, ev0[0].k, n * p, kind);
        end
      end
      checks++;
      if (pd0 !== exp_pd0) begin
        failures++;
        $display("FAIL rand%0d_pdata got=%h want=%h", t, pd0, exp_pd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_glitch();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_W, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter: PRESC_W, 6, width of the pre_scale input.
REQ-003 Parameter: STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 RX_IN  input  1  serial line, already synchronous to clk; idle high.
REQ-007 par_en  input  1  1 = frame carries a parity bit.
REQ-008 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 pre_scale  input  PRESC_W  clk cycles per bit.
REQ-010 p_data  output  DATA_W  last valid received word, LSB first on the line.
REQ-011 data_valid  output  1  one-cycle pulse when p_data is updated.
REQ-012 par_err  output  1  one-cycle pulse: parity mismatch.
REQ-013 stp_err  output  1  one-cycle pulse: a stop bit was sampled 0.
REQ-014 strt_glitch  output  1  one-cycle pulse: start bit rejected.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be: IDLE, START, DATA, PARITY, STOP, DONE.
REQ-017 par_en, par_typ and pre_scale SHALL be latched on the IDLE->START and DONE->START transitions, and held constant for the whole frame.
REQ-018 The latched prescale SHALL be forced to 8 if below 8, with its LSB cleared.
REQ-019 The edge counter SHALL be 0 on the first START cycle and SHALL count 0..P-1 (P = latched prescale), then wrap and increment the bit counter.
REQ-020 Each bit SHALL be the 2-of-3 majority of RX_IN at edges M-1, M and M+1, where M = P/2; the samples SHALL be registered.
REQ-021 IDLE: RX_IN=0 -> START; otherwise stay.
REQ-022 START, edge P-1: vote=1 -> strt_glitch pulse next cycle, go to IDLE; vote=0 -> DATA.
REQ-023 DATA: at edge P-1 of each bit, the vote SHALL shift into the deserializer LSB-first.
REQ-024 DATA, after bit DATA_W-1 at edge P-1: -> PARITY if par_en, else -> STOP.
REQ-025 PARITY: at edge P-1, compare the vote with the expected bit (XOR of data for even; inverted XOR for odd); a mismatch sets an internal flag; -> STOP.
REQ-026 STOP: for each of the STOP_BITS stop bits, a vote of 0 SHALL set the stop flag.
REQ-027 STOP: on the last stop bit, at edge P-2 -> DONE; earlier stop bits wrap at P-1 as normal.
REQ-028 DONE lasts one cycle.
REQ-029 In DONE, with no flags set: data_valid=1 and p_data loads the deserializer.
REQ-030 In DONE, with any flag set: pulse par_err and/or stp_err, no data_valid, p_data unchanged.
REQ-031 DONE: RX_IN=0 -> START (back-to-back frame, edge counter 0); otherwise -> IDLE.
REQ-032 Flags and the deserializer SHALL clear on every entry to START.
REQ-033 Pulse outputs SHALL never be high outside the cycle defined for them; par_err SHALL never pulse when the latched par_en=0.
REQ-034 Latency: data_valid SHALL occur on START-relative cycle (1+DATA_W+par_en+STOP_BITS)*P - 1.

Reset
REQ-035 rst_n low at any time (including mid-frame) SHALL immediately force IDLE and set p_data=0, data_valid=0, par_err=0, stp_err=0, strt_glitch=0, busy=0, and all counters and flags to 0.
REQ-036 After rst_n rises, no frame SHALL be decoded until RX_IN has been seen low in IDLE.

Verification
REQ-037 DATA_W=8, P=8, par_en=1, par_typ=0, frame 0xA5 with parity 0 and stop 1 -> data_valid on cycle 87 after START entry, p_data=0xA5, no errors.
REQ-038 Same frame with parity bit 1 -> par_err pulse on cycle 87, no data_valid, p_data keeps its previous value.
REQ-039 RX_IN low for 2 cycles then high, P=16 -> strt_glitch pulse, return to IDLE, busy low.
REQ-040 STOP_BITS=2, par_en=0, 0x3C with the second stop bit 0 -> stp_err pulse, no data_valid.
REQ-041 Two back-to-back frames 0x01 then 0xFE with no idle gap -> two data_valid pulses exactly one frame (P*frame_bits cycles) apart, correct data each time.
REQ-042 rst_n pulsed low during bit 4 of DATA -> all outputs 0 immediately; the next full frame 0x55 is received correctly.
